// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one UART TX FIFO write port
// among NUM_REQ byte-stream clients, with a per-grant burst cap.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          burst_cut
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [GW-1:0] LAST_ID = GW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_CAP = CW'(MAX_BURST - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          r_state;
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   r_grant_id;
  logic [CW-1:0]   r_byte_cnt;
  logic            r_burst_cut;

  logic                  w_grant_act;
  logic                  w_xfer;
  logic                  w_last;
  logic                  w_cap;
  logic                  w_found;
  logic [GW-1:0]         w_pick;
  logic [GW-1:0]         w_idx;
  logic [GW-1:0]         w_next_ptr;
  logic [NUM_REQ-1:0]    w_ready;
  logic [DATA_WIDTH-1:0] w_lane;

  // Reset gates the combinational strobes so a reset cycle never writes.
  assign w_grant_act = (r_state == S_GRANT) && !reset;
  assign w_lane      = req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign w_xfer      = w_grant_act && !fifo_full && req_valid[r_grant_id];
  assign w_last      = req_last[r_grant_id];
  assign w_cap       = (r_byte_cnt == CNT_CAP);
  assign w_next_ptr  = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;

  // Scan rr_ptr, rr_ptr+1, ... with an explicit wrap so any NUM_REQ works.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    w_idx   = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
      w_idx = (w_idx == LAST_ID) ? '0 : w_idx + 1'b1;
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_grant_act && !fifo_full) w_ready[r_grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_byte_cnt  <= '0;
      r_burst_cut <= 1'b0;
    end else begin
      r_burst_cut <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant_id <= w_pick;
            r_byte_cnt <= '0;
            r_state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_xfer) begin
            if (w_last || w_cap) begin
              r_state     <= S_IDLE;
              r_rr_ptr    <= w_next_ptr;
              r_byte_cnt  <= '0;
              r_burst_cut <= w_cap && !w_last;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = w_ready;
  assign fifo_wr_en   = w_xfer;
  assign fifo_wr_data = w_xfer ? w_lane : '0;
  assign grant_id     = r_grant_id;
  assign busy         = w_grant_act;
  assign burst_cut    = r_burst_cut;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed vector table plus corner-case sequences on a 4-client arbiter,
// and a randomized scoreboard run on a 3-client, MAX_BURST=4 instance.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        rst_a, full_a, wr_a, busy_a, cut_a;
  logic [3:0]  v_a, l_a, rdy_a;
  logic [31:0] d_a;
  logic [7:0]  wd_a;
  logic [1:0]  gid_a;

  logic        rst_b, full_b, wr_b, busy_b, cut_b;
  logic [2:0]  v_b, l_b, rdy_b;
  logic [23:0] d_b;
  logic [7:0]  wd_b;
  logic [1:0]  gid_b;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(16)) u_a (
    .clk(clk), .reset(rst_a), .req_valid(v_a), .req_data(d_a), .req_last(l_a),
    .req_ready(rdy_a), .fifo_full(full_a), .fifo_wr_en(wr_a), .fifo_wr_data(wd_a),
    .grant_id(gid_a), .busy(busy_a), .burst_cut(cut_a)
  );

  uart_tx_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(4)) u_b (
    .clk(clk), .reset(rst_b), .req_valid(v_b), .req_data(d_b), .req_last(l_b),
    .req_ready(rdy_b), .fifo_full(full_b), .fifo_wr_en(wr_b), .fifo_wr_data(wd_b),
    .grant_id(gid_b), .busy(busy_b), .burst_cut(cut_b)
  );

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic        f;
    logic [31:0] d;
    logic [16:0] exp;  // {ready, wr_en, wr_data, grant_id, busy, burst_cut}
  } vec_t;
  vec_t vq[$];

  function automatic void add(logic [3:0] v, logic [3:0] l, logic f, logic [31:0] d,
                              logic [3:0] rdy, logic wr, logic [7:0] wd,
                              logic [1:0] gid, logic bsy, logic cut);
    vec_t t;
    t.v = v; t.l = l; t.f = f; t.d = d;
    t.exp = {rdy, wr, wd, gid, bsy, cut};
    vq.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int seq, w0, cuts;
  bit done;
  int cli_seq[3], sb_seq[3], waitc[3];
  int owner, gcnt, exp_rr, exp_w, idx, total_b;
  bit cut_pend, arb_pend;
  logic [2:0] arb_v;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    v_a = '0; l_a = '0; d_a = '0; full_a = 1'b0;
    v_b = '0; l_b = '0; d_b = '0; full_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    chk("reset_state", {rdy_a, wr_a, wd_a, gid_a, busy_a, cut_a}, 17'h0);

    // Round-robin with one-byte messages: 0,1,2,3,0, an IDLE cycle after each
    add(4'hF, 4'hF, 1'b0, 32'hD3D2D1D0, 4'b0000, 0, 8'h00, 2'd0, 0, 0);
    add(4'hF, 4'hF, 1'b0, 32'hD3D2D1D0, 4'b0001, 1, 8'hD0, 2'd0, 1, 0);
    add(4'hF, 4'hF, 1'b0, 32'hD3D2D1D0, 4'b0000, 0, 8'h00, 2'd0, 0, 0);
    add(4'hF, 4'hF, 1'b0, 32'hD3D2D1D0, 4'b0010, 1, 8'hD1, 2'd1, 1, 0);
    add(4'hF, 4'hF, 1'b0, 32'hD3D2D1D0, 4'b0000, 0, 8'h00, 2'd1, 0, 0);
    add(4'hF, 4'hF, 1'b0, 32'hD3D2D1D0, 4'b0100, 1, 8'hD2, 2'd2, 1, 0);
    add(4'hF, 4'hF, 1'b0, 32'hD3D2D1D0, 4'b0000, 0, 8'h00, 2'd2, 0, 0);
    add(4'hF, 4'hF, 1'b0, 32'hD3D2D1D0, 4'b1000, 1, 8'hD3, 2'd3, 1, 0);
    add(4'hF, 4'hF, 1'b0, 32'hD3D2D1D0, 4'b0000, 0, 8'h00, 2'd3, 0, 0);
    add(4'hF, 4'hF, 1'b0, 32'hD3D2D1D0, 4'b0001, 1, 8'hD0, 2'd0, 1, 0);
    add(4'h0, 4'h0, 1'b0, 32'h0,        4'b0000, 0, 8'h00, 2'd0, 0, 0);
    // Message lock: client 1 gaps for 3 cycles while client 2 waits
    add(4'b0110, 4'b0100, 1'b0, 32'h00B2A100, 4'b0000, 0, 8'h00, 2'd0, 0, 0);
    add(4'b0110, 4'b0100, 1'b0, 32'h00B2A100, 4'b0010, 1, 8'hA1, 2'd1, 1, 0);
    for (int i = 0; i < 3; i++)
      add(4'b0100, 4'b0100, 1'b0, 32'h00B2A100, 4'b0010, 0, 8'h00, 2'd1, 1, 0);
    add(4'b0110, 4'b0110, 1'b0, 32'h00B2A200, 4'b0010, 1, 8'hA2, 2'd1, 1, 0);
    add(4'b0100, 4'b0100, 1'b0, 32'h00B20000, 4'b0000, 0, 8'h00, 2'd1, 0, 0);
    add(4'b0100, 4'b0100, 1'b0, 32'h00B20000, 4'b0100, 1, 8'hB2, 2'd2, 1, 0);
    add(4'h0, 4'h0, 1'b0, 32'h0, 4'b0000, 0, 8'h00, 2'd2, 0, 0);
    // Backpressure: full for 5 cycles mid-grant, then two bytes in order
    add(4'b1000, 4'b0000, 1'b0, 32'hC0000000, 4'b0000, 0, 8'h00, 2'd2, 0, 0);
    for (int i = 0; i < 5; i++)
      add(4'b1000, 4'b0000, 1'b1, 32'hC0000000, 4'b0000, 0, 8'h00, 2'd3, 1, 0);
    add(4'b1000, 4'b0000, 1'b0, 32'hC0000000, 4'b1000, 1, 8'hC0, 2'd3, 1, 0);
    add(4'b1000, 4'b1000, 1'b0, 32'hC1000000, 4'b1000, 1, 8'hC1, 2'd3, 1, 0);
    add(4'h0, 4'h0, 1'b0, 32'h0, 4'b0000, 0, 8'h00, 2'd3, 0, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      v_a = vq[i].v; l_a = vq[i].l; full_a = vq[i].f; d_a = vq[i].d;
      #1;
      chk($sformatf("vec%0d", i), {rdy_a, wr_a, wd_a, gid_a, busy_a, cut_a}, vq[i].exp);
    end

    // Burst cap: client 0 never sets last, client 3 waits
    seq = 0; w0 = 0; cuts = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      v_a = 4'b1001; l_a = 4'b1000; full_a = 1'b0;
      d_a = {8'h3C, 16'h0000, seq[7:0]};
      #1;
      if (wr_a && gid_a == 2'd0) begin
        chk("burst_order", wd_a, seq);
        seq++; w0++;
      end
      if (cut_a) begin
        cuts++;
        chk("cut_idle", busy_a, 1'b0);
      end
      if (busy_a && gid_a == 2'd3) begin
        done = 1'b1;
        chk("burst_next", {wr_a, wd_a}, {1'b1, 8'h3C});
      end
    end
    chk("burst_done", done, 1'b1);
    chk("burst_writes", w0, 16);
    chk("burst_cuts", cuts, 1);

    // Reset mid-burst: move rr_ptr off 0 first, then reset during client 1's grant
    @(negedge clk); v_a = 4'b0100; l_a = 4'b0100; d_a = 32'h00E20000; full_a = 1'b0;
    @(negedge clk); #1;
    chk("pre_grant2", {wr_a, gid_a, wd_a}, {1'b1, 2'd2, 8'hE2});
    @(negedge clk); v_a = 4'b0010; l_a = 4'b0000; d_a = 32'h0000E100;
    @(negedge clk); #1;
    chk("mid_burst", {wr_a, gid_a}, {1'b1, 2'd1});
    @(negedge clk); rst_a = 1'b1; #1;
    chk("rst_drop", {rdy_a, wr_a, busy_a}, 6'h0);
    repeat (3) @(negedge clk);
    rst_a = 1'b0; v_a = 4'b1011; l_a = 4'b1011; d_a = 32'hF300F1F0;
    #1;
    chk("rst_outputs", {rdy_a, wr_a, wd_a, gid_a, busy_a, cut_a}, 17'h0);
    @(negedge clk); #1;
    chk("rst_rr_zero", {rdy_a, wr_a, wd_a, gid_a, busy_a}, {4'b0001, 1'b1, 8'hF0, 2'd0, 1'b1});
    @(negedge clk); v_a = '0; l_a = '0;

    // Random scoreboard on the 3-client instance
    owner = -1; gcnt = 0; exp_rr = 0; total_b = 0;
    cut_pend = 1'b0; arb_pend = 1'b0; arb_v = '0;
    for (int k = 0; k < 3; k++) begin cli_seq[k] = 0; sb_seq[k] = 0; waitc[k] = 0; end
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      full_b = ($urandom_range(0, 4) == 0);
      for (int k = 0; k < 3; k++) begin
        v_b[k] = ($urandom_range(0, 2) != 0);
        l_b[k] = ($urandom_range(0, 3) == 0);
        d_b[k*8 +: 8] = {k[1:0], cli_seq[k][5:0]};
      end
      #1;
      chk("sb_cut", cut_b, cut_pend);
      cut_pend = 1'b0;
      if (arb_pend) begin
        exp_w = -1;
        for (int s = 0; s < 3; s++) begin
          idx = (exp_rr + s) % 3;
          if (arb_v[idx] && exp_w < 0) exp_w = idx;
        end
        chk("sb_grant", {busy_b, gid_b}, {1'b1, exp_w[1:0]});
        for (int k = 0; k < 3; k++) begin
          if (k == int'(gid_b)) waitc[k] = 0;
          else if (arb_v[k]) waitc[k]++;
          else waitc[k] = 0;
          if (arb_v[k]) chk("sb_starve", (waitc[k] <= 3), 1'b1);
        end
        arb_pend = 1'b0;
      end
      if (full_b) chk("sb_full", {wr_b, rdy_b}, 4'h0);
      if (wr_b) begin
        total_b++;
        chk("sb_src", wd_b[7:6], gid_b);
        chk("sb_seq", wd_b[5:0], sb_seq[gid_b][5:0]);
        if (owner >= 0) chk("sb_interleave", gid_b, owner);
        sb_seq[gid_b]++;
        gcnt++;
        if (l_b[gid_b] || gcnt == 4) begin
          cut_pend = !l_b[gid_b];
          owner = -1; gcnt = 0;
          exp_rr = (int'(gid_b) + 1) % 3;
        end else begin
          owner = int'(gid_b);
        end
      end
      for (int k = 0; k < 3; k++)
        if (v_b[k] && rdy_b[k]) cli_seq[k]++;
      if (!busy_b && (|v_b)) begin
        arb_pend = 1'b1;
        arb_v = v_b;
      end
    end
    chk("sb_progress", (total_b > 100), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
